// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The requester drives start and the operands; the subtractor answers
// with ready, the done pulse and the registered result fields.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  ready, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output ready, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell works on the low bits of the operand shift
// registers while the borrow is carried between cycles in a flop. The result
// registers change only on the edge that finishes the MSB, so a finished
// result stays visible through IDLE and the whole of the next operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic br_next;

  // Full-subtractor cell on the current operand bits and the running borrow.
  always_comb begin
    a_bit   = a_sh_q[0];
    b_bit   = b_sh_q[0];
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_next = (~a_bit & b_bit) | (~a_bit & br_q) | (b_bit & br_q);
  end

  // Sequencing: load on an accepted start, shift WIDTH bits, publish, then
  // spend one cycle in DONE so the done pulse is exactly one cycle wide.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    br_d      = br_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    bout_d    = bout_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        diff_sh_d = {d_bit, {(WIDTH-1){1'b0}}} | (diff_sh_q >> 1);
        br_d      = br_next;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d  = diff_sh_d;
          bout_d  = br_next;
          ovf_d   = br_q ^ br_next;
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      br_q      <= 1'b0;
      cnt_q     <= '0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      br_q      <= br_d;
      cnt_q     <= cnt_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed and random operations driven
// into the handshake, expected results computed with plain arithmetic and
// queued when the bench's own busy model says a start is accepted; a
// separate monitor pops them when they fall due and checks done timing,
// result values and the holding of the outputs in between.
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int MAX_S = (2 ** (WIDTH - 1)) - 1;
  localparam int MIN_S = -(2 ** (WIDTH - 1));

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    int unsigned      due;
  } exp_t;

  logic clk;
  logic rst;

  serial_subtractor_if #(.WIDTH(WIDTH)) sub_if ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sub_if)
  );

  exp_t             exp_q[$];
  int unsigned      cyc;
  int               busy_left;
  int               tests_run;
  int               fail_count;
  logic [WIDTH-1:0] hold_diff;
  logic             hold_bout;
  logic             hold_ovf;
  logic             rst_seen;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time-stamp when each result falls due.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // One comparison: counts it and reports a FAIL line on disagreement.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
               name, actual, expected, cyc);
    end
  endtask

  // Reference result straight from the arithmetic definition.
  function automatic exp_t model(input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic bi, input int unsigned due);
    exp_t        r;
    logic [WIDTH:0] full;
    int          s;
    full   = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(bi);
    s      = int'($signed(a)) - int'($signed(b)) - int'(bi);
    r.diff = full[WIDTH-1:0];
    r.bout = full[WIDTH];
    r.ovf  = (s > MAX_S) || (s < MIN_S);
    r.due  = due;
    return r;
  endfunction

  // Predictor: tracks when the block should be busy, checks ready against
  // that, and queues an expected result whenever the coming edge accepts.
  always @(negedge clk) begin
    checkOutput("ready", 32'(sub_if.ready), 32'(busy_left == 0));
    if (rst) begin
      busy_left = 0;
      exp_q.delete();
    end else if (busy_left == 0) begin
      if (sub_if.start) begin
        exp_q.push_back(model(sub_if.a, sub_if.b, sub_if.bin,
                              cyc + 1 + WIDTH));
        busy_left = WIDTH + 1;
      end
    end else begin
      busy_left = busy_left - 1;
    end
  end

  // Monitor: pops a result in the cycle it is due and checks it; every
  // other cycle it demands no done pulse and unchanged result outputs.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      hold_diff = '0;
      hold_bout = 1'b0;
      hold_ovf  = 1'b0;
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      checkOutput("done_pulse", 32'(sub_if.done), 32'd1);
      checkOutput("diff", 32'(sub_if.diff), 32'(e.diff));
      checkOutput("bout", 32'(sub_if.bout), 32'(e.bout));
      checkOutput("ovf", 32'(sub_if.ovf), 32'(e.ovf));
      hold_diff = e.diff;
      hold_bout = e.bout;
      hold_ovf  = e.ovf;
    end else begin
      checkOutput("no_done", 32'(sub_if.done), 32'd0);
      checkOutput("diff_hold", 32'(sub_if.diff), 32'(hold_diff));
      checkOutput("bout_hold", 32'(sub_if.bout), 32'(hold_bout));
      checkOutput("ovf_hold", 32'(sub_if.ovf), 32'(hold_ovf));
    end
    rst_seen = rst;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the request side of the handshake.
  task automatic applyStimulus(input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b,
                               input logic bi, input logic st);
    sub_if.a     = a;
    sub_if.b     = b;
    sub_if.bin   = bi;
    sub_if.start = st;
  endtask

  // One isolated operation, with operands scrambled after acceptance.
  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic bi);
    applyStimulus(a, b, bi, 1'b1);
    tick();
    applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    repeat (WIDTH + 2) tick();
  endtask

  // Guard against a hung run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    cyc        = 0;
    busy_left  = 0;
    tests_run  = 0;
    fail_count = 0;
    hold_diff  = '0;
    hold_bout  = 1'b0;
    hold_ovf   = 1'b0;
    rst_seen   = 1'b0;
    rst        = 1'b1;
    applyStimulus('0, '0, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    $display("[TB] directed operations");
    runOp(8'h5A, 8'h23, 1'b0);
    runOp(8'h00, 8'h01, 1'b0);
    runOp(8'h10, 8'h10, 1'b1);
    runOp(8'h80, 8'h01, 1'b0);
    runOp(8'h7F, 8'hFF, 1'b0);

    $display("[TB] start while busy is ignored");
    applyStimulus(8'h05, 8'h03, 1'b0, 1'b1);
    tick();
    for (int c = 1; c <= WIDTH + 3; c++) begin
      applyStimulus(8'hFF, 8'h00, 1'b0, (c == 3) || (c == 8));
      tick();
    end

    $display("[TB] reset aborts an operation");
    applyStimulus(8'h5A, 8'h23, 1'b0, 1'b1);
    tick();
    applyStimulus(8'h5A, 8'h23, 1'b0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    applyStimulus(8'hFF, 8'h00, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b0);
    tick();
    runOp(8'h09, 8'h04, 1'b0);

    $display("[TB] start held high");
    applyStimulus(8'h03, 8'h01, 1'b0, 1'b1);
    repeat (25) tick();
    applyStimulus(8'h03, 8'h01, 1'b0, 1'b0);
    repeat (WIDTH + 3) tick();

    $display("[TB] random operations");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
      tick();
      repeat ($urandom_range(WIDTH + 1, WIDTH + 4)) begin
        applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                      $urandom_range(0, 3) == 0);
        tick();
      end
    end

    applyStimulus('0, '0, 1'b0, 1'b0);
    for (int w = 0; w < 4 * WIDTH && exp_q.size() > 0; w++) begin
      tick();
    end
    repeat (2) tick();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
